fence_sequencer: RTL and testbench
==================================

# fence_sequencer

Sequences the multi-cycle memory-ordering instructions retired on commit port 0: FENCE, FENCE.I and SFENCE.VMA. Sits between the commit stage and the cache/MMU flush interfaces. It accepts one request and waits for the store buffer to drain. It then issues the D$ flush, I$ flush or TLB flush in the required order, and returns a single-cycle completion used as the commit acknowledge. It also flags drains that take too long.

## Interface
- DrainTimeout, 1024: number of DRAIN cycles after which `timeout_o` pulses; 0 disables the timeout.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous and active-low.
- req_valid_i  in  1  request from commit port 0.
- req_op_i  in  2  requested operation: 0 FENCE, 1 FENCE_I, 2 SFENCE_VMA, 3 reserved (treated as FENCE).
- req_ready_o  out  1  sequencer can accept a request; high only in IDLE.
- abort_i  in  1  pipeline flush / halt from the controller.
- no_st_pending_i  in  1  store buffer empty.
- dcache_flush_o  out  1  D$ flush request; level, held until acknowledged.
- dcache_flush_ack_i  in  1  D$ flush complete.
- icache_flush_o  out  1  I$ flush; one-cycle pulse.
- tlb_flush_o  out  1  TLB flush; one-cycle pulse.
- done_o  out  1  operation complete; one-cycle pulse.
- busy_o  out  1  state is not IDLE.
- timeout_o  out  1  drain timeout; one-cycle pulse.

## Operation
- States: IDLE, DRAIN, FLUSH_D, FLUSH_I, TLB, DONE.
- IDLE:
  - `req_ready_o=1`.
  - On `req_valid_i`, latch `req_op_i` into `op_q` and go to DRAIN.
- DRAIN: `no_st_pending_i` is sampled each cycle. When it is 1:
  - op FENCE or FENCE_I (including reserved 3) -> FLUSH_D.
  - op SFENCE_VMA -> TLB.
- FLUSH_D:
  - `dcache_flush_o=1` for the whole state.
  - On `dcache_flush_ack_i`: FENCE -> DONE; FENCE_I -> FLUSH_I.
- FLUSH_I: `icache_flush_o=1` -> DONE.
- TLB: `tlb_flush_o=1` -> DONE.
- DONE: `done_o=1` -> IDLE.
- All outputs except `timeout_o` are decoded from the state register only, with no combinational input-to-output paths.
- `timeout_o` is a registered pulse.
- Abort handling:
  - `abort_i` in DRAIN -> IDLE next cycle; no flush is issued and `done_o` is not asserted.
  - `abort_i` in IDLE blocks acceptance that cycle: abort has priority over `req_valid_i`.
  - `abort_i` in FLUSH_D, FLUSH_I, TLB or DONE is ignored. Once started, a flush always completes and `done_o` still pulses.
- Drain counter:
  - Width is `$clog2(DrainTimeout+1)`.
  - Cleared on entry to DRAIN; increments each DRAIN cycle while `no_st_pending_i=0`; saturates at DrainTimeout.
  - `timeout_o` pulses once, in the cycle after the count first reaches DrainTimeout.
  - The FSM keeps waiting after a timeout; the timeout is diagnostic only.
- `dcache_flush_ack_i` outside FLUSH_D is ignored. An ack in the same cycle FLUSH_D is entered counts.
- `req_valid_i` while not in IDLE is ignored. The requester holds it until it sees `done_o`.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready_o=1`.
  - All other outputs 0.
  - `op_q=0`, counter 0.
- Minimum latency, with stores already drained and the ack arriving in the first FLUSH_D cycle:
  - Request accepted at cycle 0.
  - DRAIN at cycle 1.
  - FLUSH_D at cycle 2 with the ack.
  - `done_o` at cycle 3.
- Minimum latency for FENCE_I: `icache_flush_o` at cycle 3, `done_o` at cycle 4.
- Minimum latency for SFENCE_VMA: `tlb_flush_o` at cycle 2, `done_o` at cycle 3.
- Back-to-back: a new request can be accepted in the cycle after DONE (IDLE).
- Reset asserted mid-operation: immediate return to reset values; a pending D$ flush request is dropped.

## Test plan
- FENCE with `no_st_pending_i=1` and ack in the first FLUSH_D cycle -> `dcache_flush_o` high for exactly 1 cycle, `done_o` at cycle 3, `icache_flush_o` and `tlb_flush_o` stay 0.
- FENCE_I with `no_st_pending_i=0` for 5 cycles and ack delayed by 3 cycles -> `dcache_flush_o` high for 4 cycles, then `icache_flush_o` pulse, then `done_o`.
- SFENCE_VMA -> `tlb_flush_o` pulse, `done_o` one cycle later, `dcache_flush_o` never asserted.
- Abort handling:
  - `abort_i` in DRAIN -> IDLE next cycle, no `done_o`.
  - `abort_i` in FLUSH_D -> still waits for the ack and pulses `done_o`.
- Timeout with `DrainTimeout=8` and `no_st_pending_i=0` for 20 cycles -> a single `timeout_o` pulse 9 cycles after DRAIN entry, then normal completion once the drain finishes.
- `rst_ni` low in FLUSH_D -> `dcache_flush_o` and `busy_o` drop to 0 and `req_ready_o` goes to 1 immediately; a stale ack after reset has no effect.

Source files
------------

// File: rtl/fence_sequencer_if.sv
// Commit-port / flush-interface bundle for the fence sequencer.
// The slave modport is the sequencer; the master modport is the commit stage plus the cache/MMU side.
interface fence_sequencer_if;
  logic       req_valid_i;
  logic [1:0] req_op_i;
  logic       req_ready_o;
  logic       abort_i;
  logic       no_st_pending_i;
  logic       dcache_flush_o;
  logic       dcache_flush_ack_i;
  logic       icache_flush_o;
  logic       tlb_flush_o;
  logic       done_o;
  logic       busy_o;
  logic       timeout_o;

  modport slave (
    input  req_valid_i, req_op_i, abort_i, no_st_pending_i, dcache_flush_ack_i,
    output req_ready_o, dcache_flush_o, icache_flush_o, tlb_flush_o, done_o, busy_o, timeout_o
  );

  modport master (
    output req_valid_i, req_op_i, abort_i, no_st_pending_i, dcache_flush_ack_i,
    input  req_ready_o, dcache_flush_o, icache_flush_o, tlb_flush_o, done_o, busy_o, timeout_o
  );
endinterface

// File: rtl/fence_sequencer.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA: drain stores, issue flushes in order, pulse done.
// Every output is a flop loaded from the next-state decode, so no input reaches an output combinationally.
module fence_sequencer #(
  parameter int unsigned DrainTimeout = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  fence_sequencer_if.slave  bus
);

  localparam int unsigned CntW      = (DrainTimeout > 0) ? $clog2(DrainTimeout + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DrainTimeout);
  localparam bit          TimeoutEn = (DrainTimeout != 0);

  localparam logic [1:0] OpFenceI  = 2'd1;
  localparam logic [1:0] OpSfence  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH_D,
    S_FLUSH_I,
    S_TLB,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q;
  logic [CntW-1:0]   cnt_q;
  logic              fired_q;
  logic              ready_q, busy_q, dflush_q, iflush_q, tlb_q, done_q, timeout_q;
  logic              accept_c;
  logic              tick_c;

  // Abort wins over a new request in IDLE
  assign accept_c = (state_q == S_IDLE) && bus.req_valid_i && !bus.abort_i;

  // Timeout fires once per operation, the cycle after the count saturates
  assign tick_c = TimeoutEn && (cnt_q == CntMax) && !fired_q && !accept_c;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept_c) state_d = S_DRAIN;
      S_DRAIN: begin
        if (bus.abort_i)              state_d = S_IDLE;
        else if (bus.no_st_pending_i) state_d = (op_q == OpSfence) ? S_TLB : S_FLUSH_D;
      end
      // Reserved op 3 behaves as plain FENCE
      S_FLUSH_D: if (bus.dcache_flush_ack_i) state_d = (op_q == OpFenceI) ? S_FLUSH_I : S_DONE;
      S_FLUSH_I: state_d = S_DONE;
      S_TLB:     state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      op_q      <= 2'd0;
      cnt_q     <= '0;
      fired_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      dflush_q  <= 1'b0;
      iflush_q  <= 1'b0;
      tlb_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_c) op_q <= bus.req_op_i;

      if (accept_c) begin
        cnt_q   <= '0;
        fired_q <= 1'b0;
      end else begin
        if ((state_q == S_DRAIN) && !bus.no_st_pending_i && (cnt_q != CntMax))
          cnt_q <= cnt_q + CntW'(1);
        if (tick_c) fired_q <= 1'b1;
      end

      timeout_q <= tick_c;
      ready_q   <= (state_d == S_IDLE);
      busy_q    <= (state_d != S_IDLE);
      dflush_q  <= (state_d == S_FLUSH_D);
      iflush_q  <= (state_d == S_FLUSH_I);
      tlb_q     <= (state_d == S_TLB);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign bus.req_ready_o    = ready_q;
  assign bus.busy_o         = busy_q;
  assign bus.dcache_flush_o = dflush_q;
  assign bus.icache_flush_o = iflush_q;
  assign bus.tlb_flush_o    = tlb_q;
  assign bus.done_o         = done_q;
  assign bus.timeout_o      = timeout_q;

endmodule

// File: tb/tb_fence_sequencer.sv
// Directed table-driven bench for fence_sequencer (DrainTimeout = 8).
// Each record drives inputs for one cycle and gives the outputs expected after that clock edge.
module tb_fence_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fence_sequencer_if sq_if ();

  fence_sequencer #(.DrainTimeout(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (sq_if)
  );

  // Output vector order: {ready, busy, dflush, iflush, tlb, done, timeout}
  localparam logic [6:0] O_IDLE  = 7'b1000000;
  localparam logic [6:0] O_DRAIN = 7'b0100000;
  localparam logic [6:0] O_FD    = 7'b0110000;
  localparam logic [6:0] O_FI    = 7'b0101000;
  localparam logic [6:0] O_TLB   = 7'b0100100;
  localparam logic [6:0] O_DONE  = 7'b0100010;
  localparam logic [6:0] O_TMO   = 7'b0000001;

  typedef struct {
    string      name;
    logic       valid;
    logic [1:0] op;
    logic       abort;
    logic       no_st;
    logic       ack;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [6:0] outs();
    return {sq_if.req_ready_o, sq_if.busy_o, sq_if.dcache_flush_o, sq_if.icache_flush_o,
            sq_if.tlb_flush_o, sq_if.done_o, sq_if.timeout_o};
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = outs();
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (rdy,busy,dfl,ifl,tlb,done,tmo)", name, got, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic ab,
                       input logic ns, input logic ack);
    sq_if.req_valid_i        = v;
    sq_if.req_op_i           = op;
    sq_if.abort_i            = ab;
    sq_if.no_st_pending_i    = ns;
    sq_if.dcache_flush_ack_i = ack;
  endtask

  function automatic void add(input string name, input logic v, input logic [1:0] op,
                              input logic ab, input logic ns, input logic ack,
                              input logic [6:0] exp);
    vec_t r;
    r.name  = name;
    r.valid = v;
    r.op    = op;
    r.abort = ab;
    r.no_st = ns;
    r.ack   = ack;
    r.exp   = exp;
    vecs.push_back(r);
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #12;
    check("reset", O_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // FENCE at minimum latency, then a request already waiting in DONE
    add("fence",  1, 2'd0, 0, 1, 0, O_DRAIN);
    add("fence",  1, 2'd0, 0, 1, 0, O_FD);
    add("fence",  1, 2'd0, 0, 0, 1, O_DONE);
    add("b2b",    1, 2'd2, 0, 1, 0, O_IDLE);
    // SFENCE.VMA accepted in the IDLE cycle right after DONE; stray ack is ignored
    add("sfence", 1, 2'd2, 0, 1, 0, O_DRAIN);
    add("sfence", 1, 2'd2, 0, 1, 0, O_TLB);
    add("sfence", 1, 2'd2, 0, 1, 1, O_DONE);
    add("sfence", 0, 2'd0, 0, 1, 0, O_IDLE);
    // FENCE.I: five undrained cycles, ack in the fourth FLUSH_D cycle
    add("fencei", 1, 2'd1, 0, 0, 0, O_DRAIN);
    for (int k = 0; k < 5; k++) add("fencei_drain", 1, 2'd1, 0, 0, 0, O_DRAIN);
    add("fencei", 1, 2'd1, 0, 1, 0, O_FD);
    for (int k = 0; k < 3; k++) add("fencei_wait", 1, 2'd1, 0, 0, 0, O_FD);
    add("fencei", 1, 2'd1, 0, 0, 1, O_FI);
    add("fencei", 1, 2'd1, 0, 0, 0, O_DONE);
    add("fencei", 0, 2'd0, 0, 0, 0, O_IDLE);
    // Reserved op behaves as FENCE
    add("op3",    1, 2'd3, 0, 1, 0, O_DRAIN);
    add("op3",    1, 2'd3, 0, 1, 0, O_FD);
    add("op3",    1, 2'd3, 0, 0, 1, O_DONE);
    add("op3",    0, 2'd0, 0, 0, 0, O_IDLE);
    // Abort in DRAIN, abort blocking IDLE accept, abort ignored in FLUSH_D / DONE
    add("abort_drain", 1, 2'd0, 0, 0, 0, O_DRAIN);
    add("abort_drain", 1, 2'd0, 1, 1, 0, O_IDLE);
    add("abort_idle",  1, 2'd0, 1, 1, 0, O_IDLE);
    add("abort_fd",    1, 2'd0, 0, 1, 0, O_DRAIN);
    add("abort_fd",    1, 2'd0, 0, 1, 0, O_FD);
    add("abort_fd",    1, 2'd0, 1, 0, 0, O_FD);
    add("abort_fd",    1, 2'd0, 1, 0, 1, O_DONE);
    add("abort_done",  0, 2'd0, 1, 0, 0, O_IDLE);
    // Drain timeout: single pulse 9 cycles after DRAIN entry, then normal completion
    add("tmo", 1, 2'd0, 0, 0, 0, O_DRAIN);
    for (int k = 1; k <= 20; k++)
      add("tmo_drain", 1, 2'd0, 0, 0, 0, (k == 9) ? (O_DRAIN | O_TMO) : O_DRAIN);
    add("tmo", 1, 2'd0, 0, 1, 0, O_FD);
    add("tmo", 1, 2'd0, 0, 0, 1, O_DONE);
    add("tmo", 0, 2'd0, 0, 0, 0, O_IDLE);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].op, vecs[i].abort, vecs[i].no_st, vecs[i].ack);
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].exp);
    end

    // Asynchronous reset while a D$ flush is outstanding
    @(negedge clk);
    drive(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("rst_seq_drain", O_DRAIN);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("rst_seq_fd", O_FD);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_flush", O_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("stale_ack", O_IDLE);
    @(negedge clk);
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("stale_ack2", O_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
